// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way request arbiter.
// Used by request_arbiter_8 and arb_priority_pick.
package arb_pkg;
   localparam int ARB_N        = 8;
   localparam int ARB_IDW      = 3;
   localparam int ARB_MAX_HOLD = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;
endpackage

// File: rtl/arb_priority_pick.sv
// Combinational pick: first set bit of vec at or after index start, wrapping.
// valid is low when vec is all-zero.
module arb_priority_pick
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0]   vec,
   input  logic [ARB_IDW-1:0] start,
   output logic [ARB_IDW-1:0] idx,
   output logic               valid
);
   logic [ARB_N-1:0]   rot;
   logic [ARB_IDW-1:0] offset;

   // rot[k] is the requester k positions after start
   genvar gi;
   generate
      for (gi = 0; gi < ARB_N; gi++) begin : g_rot
         logic [ARB_IDW-1:0] src;
         assign src     = start + ARB_IDW'(gi);
         assign rot[gi] = vec[src];
      end
   endgenerate

   always_comb begin
      offset = '0;
      for (int i = ARB_N - 1; i >= 0; i--) begin
         if (rot[i]) offset = ARB_IDW'(i);
      end
      idx   = start + offset;
      valid = |vec;
   end
endmodule

// File: rtl/request_arbiter_8.sv
// Eight-requester arbiter with one-hot registered grant, hold limit and timeout mask.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module request_arbiter_8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = ARB_MAX_HOLD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [ARB_N-1:0]   req,
   output logic [ARB_N-1:0]   grant,
   output logic [ARB_IDW-1:0] grant_id,
   output logic               busy,
   output logic               timeout
);
   localparam logic [4:0] HOLD_LIMIT = 5'(MAX_HOLD - 1);

   arb_state_t         state_reg, state_next;
   logic [ARB_N-1:0]   grant_reg, grant_next;
   logic [ARB_IDW-1:0] grant_id_reg, grant_id_next;
   logic               busy_reg, busy_next;
   logic               timeout_reg, timeout_next;
   logic [4:0]         hold_cnt_reg, hold_cnt_next;
   logic [ARB_N-1:0]   mask_reg, mask_next;

   logic [ARB_N-1:0]   cand;
   logic [ARB_N-1:0]   pick_vec;
   logic [ARB_IDW-1:0] start;
   logic [ARB_IDW-1:0] win_id;
   logic               win_valid;
   logic               issue;

   // A masked requester is only skipped while someone else is asking
   assign cand     = req & ~mask_reg;
   assign pick_vec = (cand != '0) ? cand : req;
   assign issue    = ((state_reg == IDLE) || (state_reg == RELEASE)) && en && win_valid;

`ifdef ARB_ROUND_ROBIN_EN
   logic [ARB_IDW-1:0] last_id_reg, last_id_next;

   assign start = last_id_reg + 3'd1;

   always_comb begin
      last_id_next = last_id_reg;
      if (issue) last_id_next = win_id;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_id_reg <= 3'd7;
      else     last_id_reg <= last_id_next;
   end
`else
   assign start = '0;
`endif

   arb_priority_pick u_pick (
      .vec   (pick_vec),
      .start (start),
      .idx   (win_id),
      .valid (win_valid)
   );

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      grant_id_next = grant_id_reg;
      busy_next     = busy_reg;
      timeout_next  = 1'b0;
      hold_cnt_next = hold_cnt_reg;
      mask_next     = mask_reg;

      case (state_reg)
         GRANT: begin
            hold_cnt_next = hold_cnt_reg + 5'd1;
            if (!req[grant_id_reg]) begin
               state_next    = RELEASE;
               grant_next    = '0;
               grant_id_next = '0;
               busy_next     = 1'b0;
            end else if (hold_cnt_reg == HOLD_LIMIT) begin
               state_next              = RELEASE;
               grant_next              = '0;
               grant_id_next           = '0;
               busy_next               = 1'b0;
               timeout_next            = 1'b1;
               mask_next[grant_id_reg] = 1'b1;
            end
         end
         default: begin
            if (issue) begin
               state_next    = GRANT;
               grant_next    = ARB_N'(1) << win_id;
               grant_id_next = win_id;
               busy_next     = 1'b1;
               hold_cnt_next = '0;
               // Any issued grant ends the penalty, including a fallback regrant
               mask_next     = '0;
            end else begin
               state_next    = IDLE;
               grant_next    = '0;
               grant_id_next = '0;
               busy_next     = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         grant_id_reg <= '0;
         busy_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
         hold_cnt_reg <= '0;
         mask_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         grant_id_reg <= grant_id_next;
         busy_reg     <= busy_next;
         timeout_reg  <= timeout_next;
         hold_cnt_reg <= hold_cnt_next;
         mask_reg     <= mask_next;
      end
   end

   assign grant    = grant_reg;
   assign grant_id = grant_id_reg;
   assign busy     = busy_reg;
   assign timeout  = timeout_reg;
endmodule

// File: tb/tb_request_arbiter_8.sv
// Table-driven, scoreboarded bench for request_arbiter_8 with MAX_HOLD=4.
// Expectations hold for both the fixed and ARB_ROUND_ROBIN_EN builds.
module tb_request_arbiter_8;
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       busy;
   logic       timeout;

   always #5 clk = ~clk;

   request_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .req      (req),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   typedef struct {
      string      name;
      logic       en;
      logic [7:0] req;
      logic [7:0] grant;
      logic [2:0] id;
      logic       busy;
      logic       to;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] grant;
      logic [2:0] id;
      logic       busy;
      logic       to;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(string name, logic e, logic [7:0] r, logic [7:0] g,
                               logic [2:0] i, logic b, logic t);
      vec_t v;
      v.name = name; v.en = e; v.req = r; v.grant = g; v.id = i; v.busy = b; v.to = t;
      return v;
   endfunction

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if ({grant, grant_id, busy, timeout} !== {e.grant, e.id, e.busy, e.to}) begin
         n_bad++;
         $display("FAIL %s: got grant=%h id=%0d busy=%b timeout=%b, need grant=%h id=%0d busy=%b timeout=%b",
                  e.name, grant, grant_id, busy, timeout, e.grant, e.id, e.busy, e.to);
      end else begin
         $display("ok   %s: grant=%h id=%0d busy=%b timeout=%b",
                  e.name, grant, grant_id, busy, timeout);
      end
   endtask

   task automatic expect_now(string name, logic [7:0] g, logic [2:0] i, logic b, logic t);
      sb.push_back('{name: name, grant: g, id: i, busy: b, to: t});
      check_out();
   endtask

   task automatic step(vec_t v);
      en  = v.en;
      req = v.req;
      sb.push_back('{name: v.name, grant: v.grant, id: v.id, busy: v.busy, to: v.to});
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      req = 8'h00;

      // enable gating and fixed priority
      vecs.push_back(mk("en_off0",     0, 8'hFF, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("en_off1",     0, 8'hFF, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("en_on",       1, 8'hFF, 8'h01, 3'd0, 1, 0));
      vecs.push_back(mk("en_low_hold", 0, 8'hFF, 8'h01, 3'd0, 1, 0));
      vecs.push_back(mk("drop0",       0, 8'hFE, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("rel_to_idle", 0, 8'hFE, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("idle_quiet",  0, 8'h00, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("fp_grant2",   1, 8'hA4, 8'h04, 3'd2, 1, 0));
      vecs.push_back(mk("fp_drop2",    1, 8'hA0, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("fp_grant5",   1, 8'hA0, 8'h20, 3'd5, 1, 0));
      vecs.push_back(mk("fp_drop5",    1, 8'h80, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("fp_grant7",   1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("fp_drop7",    1, 8'h00, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("fp_idle",     1, 8'h00, 8'h00, 3'd0, 0, 0));
      // hold limit with a competing requester
      vecs.push_back(mk("to_g1",       1, 8'h03, 8'h01, 3'd0, 1, 0));
      vecs.push_back(mk("to_g2",       1, 8'h03, 8'h01, 3'd0, 1, 0));
      vecs.push_back(mk("to_g3",       1, 8'h03, 8'h01, 3'd0, 1, 0));
      vecs.push_back(mk("to_g4",       1, 8'h03, 8'h01, 3'd0, 1, 0));
      vecs.push_back(mk("to_pulse",    1, 8'h03, 8'h00, 3'd0, 0, 1));
      vecs.push_back(mk("to_mask1",    1, 8'h03, 8'h02, 3'd1, 1, 0));
      vecs.push_back(mk("to_drop1",    1, 8'h01, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("to_regrant0", 1, 8'h01, 8'h01, 3'd0, 1, 0));
      vecs.push_back(mk("to_drop0",    1, 8'h00, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("to_idle",     1, 8'h00, 8'h00, 3'd0, 0, 0));
      // lone requester: fallback regrant, then drop coinciding with the limit
      vecs.push_back(mk("lo_g1",       1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_g2",       1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_g3",       1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_g4",       1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_pulse",    1, 8'h80, 8'h00, 3'd0, 0, 1));
      vecs.push_back(mk("lo_regrant",  1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_h2",       1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_h3",       1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_h4",       1, 8'h80, 8'h80, 3'd7, 1, 0));
      vecs.push_back(mk("lo_drop_lim", 1, 8'h00, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk("lo_idle",     1, 8'h00, 8'h00, 3'd0, 0, 0));

      @(posedge clk);
      #1;
      expect_now("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[i]) step(vecs[i]);

      // asynchronous reset in the middle of a grant
      step(mk("rst_grant", 1, 8'h10, 8'h10, 3'd4, 1, 0));
      step(mk("rst_hold",  1, 8'h10, 8'h10, 3'd4, 1, 0));
      #2 rst = 1'b1;
      #1 expect_now("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      step(mk("rst_regrant", 1, 8'h10, 8'h10, 3'd4, 1, 0));
      step(mk("rst_drop",    1, 8'h00, 8'h00, 3'd0, 0, 0));
      step(mk("rst_idle",    0, 8'h00, 8'h00, 3'd0, 0, 0));

      // fresh reset so rotation starts from index 0
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < 9; k++) begin
         logic [2:0] id;
         logic [7:0] oh;
`ifdef ARB_ROUND_ROBIN_EN
         id = 3'(k % 8);
`else
         id = 3'd0;
`endif
         oh = 8'd1 << id;
         step(mk($sformatf("rr_grant%0d", k), 1, 8'hFF, oh, id, 1, 0));
         step(mk($sformatf("rr_drop%0d", k), 1, 8'hFF & ~oh, 8'h00, 3'd0, 0, 0));
      end
      step(mk("rr_idle", 1, 8'h00, 8'h00, 3'd0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
